apb_dmem_responder: RTL and testbench
=====================================

// Module: apb_dmem_responder
// PURPOSE
//  APB completer (slave) end of the processor's data-memory interface: decodes psel/penable/pwrite
//  from the pipeline's memory stage and services 16-bit reads/writes into a local word array.
//  Inserts a programmable number of wait states via pready, flags bad addresses on pslverr.
//  Sits between the Integration2 memory-stage master signals and the data storage.
// PARAMETERS
//  ADDR_W       6    address width (word addressed, matches memaddr)
//  DATA_W       16   data word width
//  DEPTH        48   implemented words; addresses >= DEPTH are out of range
//  WAIT_CYCLES  1    wait states inserted in ACCESS before pready (0..15)
// PORTS
//  clk      in   1       rising-edge clock
//  rst      in   1       asynchronous, active-high reset
//  psel     in   1       transfer select from master
//  penable  in   1       access phase indicator
//  pwrite   in   1       1=write, 0=read (sampled in SETUP)
//  paddr    in   ADDR_W  word address (sampled in SETUP)
//  pwdata   in   DATA_W  write data (sampled on completing edge)
//  prdata   out  DATA_W  read data, valid while pready=1 on a read
//  pready   out  1       transfer completes this cycle
//  pslverr  out  1       error response, valid only with pready
// BEHAVIOUR
//  - Reset: prdata=0, pready=0, pslverr=0, state=IDLE, wait counter=0, all DEPTH words=0.
//  - FSM IDLE -> SETUP on psel&~penable; latch pwrite,paddr; counter cleared.
//  - SETUP -> ACCESS next cycle (master must raise penable); if psel&penable not seen in ACCESS, abort.
//  - ACCESS: counter increments each cycle; pready=1 (registered) in the cycle counter==WAIT_CYCLES.
//    WAIT_CYCLES=0 -> 2-cycle transfer; WAIT_CYCLES=N -> N+2 cycles from SETUP to completion.
//  - Completing edge (psel&penable&pready): write commits mem[addr]<=pwdata; read drives
//    prdata=mem[addr] during the pready cycle; prdata returns to 0 next cycle.
//  - After completion: psel&~penable -> SETUP (back-to-back, no idle cycle); else IDLE.
//  - psel drops during ACCESS before pready: abort, no write, pready stays 0, -> IDLE.
//  - penable high while IDLE (no SETUP): ignored, stay IDLE, pready 0.
//  - paddr/pwrite changes after SETUP ignored (latched copy used).
//  - Reset mid-transfer: all outputs to reset values immediately; pending write never commits.
//  - pready/pslverr never asserted outside ACCESS; pready is high for exactly one cycle per transfer.
// CONFIGURATION
//  DMEM_PSLVERR_EN defined: latched addr >= DEPTH -> pslverr=1 with pready, write suppressed,
//    prdata=0.
//  Not defined: pslverr tied 0; out-of-range writes silently dropped, reads return 0.
//  In-range behaviour identical in both builds.
// STRUCTURE
//  Shared header apb_dmem_defs.v: state encodings (IDLE=2'd0, SETUP=2'd1, ACCESS=2'd2),
//    ADDR_W/DATA_W defaults, WAIT_CNT_W=4.
//  One sub-module dmem_array: DEPTH x DATA_W storage, async-reset to 0, 1 write port
//    (we, waddr, wdata), combinational read port; FSM and wait counter stay in top.
// TESTING
//  1 WAIT_CYCLES=0: write 0xBEEF to addr 5, read addr 5 -> pready on 2nd cycle each, prdata=0xBEEF.
//  2 WAIT_CYCLES=3: read addr 0 after reset -> pready in 5th cycle from SETUP, prdata=0x0000.
//  3 Back-to-back write addr 1=0x1234 then read addr 1 with no idle -> second SETUP immediately
//    follows pready; read returns 0x1234.
//  4 Abort: write addr 7=0x5555, drop psel before pready; later read addr 7 -> 0x0000.
//  5 Addr 50 write 0xAAAA with DMEM_PSLVERR_EN -> pslverr=1 with pready; without -> pslverr=0;
//    read of addr 50 returns 0 in both builds.
//  6 Assert rst during ACCESS of write addr 3=0x0F0F -> outputs 0 at once; read addr 3 -> 0x0000.

Source files
------------

// File: rtl/apb_dmem_responder_pkg.sv
// Shared definitions for the APB data-memory responder: FSM phase encodings,
// default widths and the wait-state counter width.
package apb_dmem_responder_pkg;
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;

  localparam int ADDR_W_DEF = 6;
  localparam int DATA_W_DEF = 16;
  localparam int WAIT_CNT_W = 4;
endpackage

// File: rtl/apb_dmem_responder_dmem_array.sv
// DEPTH x DATA_W word storage: async reset to zero, one write port, combinational
// read port that returns zero for addresses past the implemented depth.
module apb_dmem_responder_dmem_array #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 48
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we && ({1'b0, waddr} < DEPTH_C)) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = ({1'b0, raddr} < DEPTH_C) ? mem_q[raddr] : '0;
endmodule

// File: rtl/apb_dmem_responder.sv
// APB completer for the data-memory port with programmable wait states.
// Define DMEM_PSLVERR_EN to report out-of-range addresses on pslverr.
module apb_dmem_responder
  import apb_dmem_responder_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int DEPTH       = 48,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr
);
  localparam logic [WAIT_CNT_W-1:0] WAIT_C  = WAIT_CNT_W'(WAIT_CYCLES);
  localparam logic [ADDR_W:0]       DEPTH_C = (ADDR_W+1)'(DEPTH);

  logic [1:0]            state_q, state_d, phase;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic                  wr_q, wr_d;
  logic                  pready_q, pready_d;
  logic                  in_range, we;
  logic [DATA_W-1:0]     rdata;

  assign in_range = ({1'b0, addr_q} < DEPTH_C);

  // The SETUP phase is the bus cycle in which the master presents psel without
  // penable; it is decoded from IDLE so pready can already be registered for
  // the very next cycle when no wait states are configured.
  always_comb begin
    phase = state_q;
    if (state_q == IDLE && psel && !penable) phase = SETUP;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wr_d     = wr_q;
    pready_d = 1'b0;
    we       = 1'b0;
    case (phase)
      SETUP: begin
        state_d  = ACCESS;
        addr_d   = paddr;
        wr_d     = pwrite;
        cnt_d    = '0;
        pready_d = (WAIT_C == '0);
      end
      ACCESS: begin
        if (!(psel && penable)) begin
          state_d = IDLE;
        end else if (pready_q) begin
          we      = wr_q && in_range;
          state_d = IDLE;
        end else begin
          cnt_d    = cnt_q + 1'b1;
          pready_d = ((cnt_q + 1'b1) == WAIT_C);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      wr_q     <= 1'b0;
      pready_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wr_q     <= wr_d;
      pready_q <= pready_d;
    end
  end

  apb_dmem_responder_dmem_array #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_array (
    .clk  (clk),
    .rst  (rst),
    .we   (we),
    .waddr(addr_q),
    .wdata(pwdata),
    .raddr(addr_q),
    .rdata(rdata)
  );

  assign pready = pready_q;
  assign prdata = (pready_q && !wr_q && in_range) ? rdata : '0;

`ifdef DMEM_PSLVERR_EN
  logic pslverr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pslverr_q <= 1'b0;
    else     pslverr_q <= pready_d && !({1'b0, addr_d} < DEPTH_C);
  end

  assign pslverr = pslverr_q;
`else
  assign pslverr = 1'b0;
`endif
endmodule

// File: tb/tb_apb_dmem_responder.sv
// Bench for apb_dmem_responder: two instances (0 and 3 wait states) driven by
// directed APB transfers, checked every cycle against a transfer-level model.
module tb_apb_dmem_responder;
  localparam int AW    = 6;
  localparam int DW    = 16;
  localparam int DEPTH = 48;
  localparam int W0    = 0;
  localparam int W1    = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_a    [2];
  logic          psel_a   [2];
  logic          pen_a    [2];
  logic          pwr_a    [2];
  logic [AW-1:0] paddr_a  [2];
  logic [DW-1:0] pwdata_a [2];
  logic [DW-1:0] prdata_a [2];
  logic          prdy_a   [2];
  logic          perr_a   [2];

  apb_dmem_responder #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .WAIT_CYCLES(W0)) dut0 (
    .clk(clk), .rst(rst_a[0]), .psel(psel_a[0]), .penable(pen_a[0]), .pwrite(pwr_a[0]),
    .paddr(paddr_a[0]), .pwdata(pwdata_a[0]), .prdata(prdata_a[0]), .pready(prdy_a[0]),
    .pslverr(perr_a[0]));

  apb_dmem_responder #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .WAIT_CYCLES(W1)) dut1 (
    .clk(clk), .rst(rst_a[1]), .psel(psel_a[1]), .penable(pen_a[1]), .pwrite(pwr_a[1]),
    .paddr(paddr_a[1]), .pwdata(pwdata_a[1]), .prdata(prdata_a[1]), .pready(prdy_a[1]),
    .pslverr(perr_a[1]));

  logic          exp_rdy [2];
  logic          exp_err [2];
  logic [DW-1:0] exp_rd  [2];
  logic [DW-1:0] mm      [2][64];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int wc(input int d);
    return (d == 0) ? W0 : W1;
  endfunction

  function automatic logic [DW-1:0] model_rd(input int d, input int addr);
    return (addr < DEPTH) ? mm[d][addr] : '0;
  endfunction

  function automatic logic model_err(input int addr);
`ifdef DMEM_PSLVERR_EN
    return addr >= DEPTH;
`else
    return (addr < 0);
`endif
  endfunction

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("pready[%0d]", d), 32'(prdy_a[d]), 32'(exp_rdy[d]));
      chk($sformatf("pslverr[%0d]", d), 32'(perr_a[d]), 32'(exp_err[d]));
      chk($sformatf("prdata[%0d]", d), 32'(prdata_a[d]), 32'(exp_rd[d]));
    end
  end

  task automatic set_idle_exp(input int d);
    exp_rdy[d] = 1'b0;
    exp_err[d] = 1'b0;
    exp_rd[d]  = '0;
  endtask

  task automatic idle(input int d, input int n);
    repeat (n) begin
      @(posedge clk); #1;
      psel_a[d] = 1'b0;
      pen_a[d]  = 1'b0;
      set_idle_exp(d);
    end
  endtask

  // One APB transfer; abort_k / rst_k select the access cycle at which psel is
  // dropped or reset is asserted (-1 = never). Returns observed latency/data.
  task automatic xfer(input int d, input bit wr, input int addr, input logic [DW-1:0] data,
                      input int abort_k, input int rst_k,
                      output int lat, output logic [DW-1:0] rd, output logic er);
    bit last;
    lat = 0;
    rd  = '0;
    er  = 1'b0;
    @(posedge clk); #1;
    psel_a[d] = 1'b1; pen_a[d] = 1'b0; pwr_a[d] = wr;
    paddr_a[d] = AW'(addr); pwdata_a[d] = ~data;
    set_idle_exp(d);
    for (int k = 0; k <= wc(d); k++) begin
      @(posedge clk); #1;
      if (k == abort_k) begin
        psel_a[d] = 1'b0; pen_a[d] = 1'b0;
        set_idle_exp(d);
        return;
      end
      psel_a[d] = 1'b1; pen_a[d] = 1'b1; pwr_a[d] = !wr;
      paddr_a[d] = AW'(addr) ^ 6'h2A; pwdata_a[d] = data;
      last = (k == wc(d));
      exp_rdy[d] = last;
      exp_rd[d]  = (last && !wr) ? model_rd(d, addr) : '0;
      exp_err[d] = last && model_err(addr);
      if (k == rst_k) begin
        #1;
        rst_a[d] = 1'b1;
        set_idle_exp(d);
        @(posedge clk); #1;
        psel_a[d] = 1'b0; pen_a[d] = 1'b0;
        @(posedge clk); #1;
        rst_a[d] = 1'b0;
        for (int i = 0; i < 64; i++) mm[d][i] = '0;
        return;
      end
      @(negedge clk);
      if (prdy_a[d] && lat == 0) begin
        lat = k + 2;
        rd  = prdata_a[d];
        er  = perr_a[d];
      end
    end
    if (wr && addr < DEPTH) mm[d][addr] = data;
  endtask

  initial begin
    int lat;
    logic [DW-1:0] rd;
    logic er;
    logic exp_oor_err;
`ifdef DMEM_PSLVERR_EN
    exp_oor_err = 1'b1;
`else
    exp_oor_err = 1'b0;
`endif
    for (int d = 0; d < 2; d++) begin
      rst_a[d] = 1'b1; psel_a[d] = 1'b0; pen_a[d] = 1'b0; pwr_a[d] = 1'b0;
      paddr_a[d] = '0; pwdata_a[d] = '0;
      set_idle_exp(d);
      for (int i = 0; i < 64; i++) mm[d][i] = '0;
    end
    @(negedge clk);
    chk("reset_pready", 32'(prdy_a[1]), 32'h0);
    chk("reset_prdata", 32'(prdata_a[1]), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_a[0] = 1'b0; rst_a[1] = 1'b0;

    // zero wait states: write then read back
    xfer(0, 1'b1, 5, 16'hBEEF, -1, -1, lat, rd, er);
    chk("t1_wr_latency", 32'(lat), 32'd2);
    xfer(0, 1'b0, 5, 16'h0000, -1, -1, lat, rd, er);
    chk("t1_rd_latency", 32'(lat), 32'd2);
    chk("t1_rd_data", 32'(rd), 32'hBEEF);
    xfer(0, 1'b1, 9, 16'hC3A5, -1, -1, lat, rd, er);
    xfer(0, 1'b0, 9, 16'h0000, -1, -1, lat, rd, er);
    chk("t1_b2b_data", 32'(rd), 32'hC3A5);
    // penable without a preceding setup is ignored
    @(posedge clk); #1;
    psel_a[0] = 1'b0; pen_a[0] = 1'b1; set_idle_exp(0);
    @(posedge clk); #1;
    psel_a[0] = 1'b1; pen_a[0] = 1'b1;
    idle(0, 1);

    // three wait states: read of untouched word
    xfer(1, 1'b0, 0, 16'h0000, -1, -1, lat, rd, er);
    chk("t2_rd_latency", 32'(lat), 32'd5);
    chk("t2_rd_data", 32'(rd), 32'h0);
    idle(1, 1);

    // back-to-back write/read
    xfer(1, 1'b1, 1, 16'h1234, -1, -1, lat, rd, er);
    xfer(1, 1'b0, 1, 16'h0000, -1, -1, lat, rd, er);
    chk("t3_rd_latency", 32'(lat), 32'd5);
    chk("t3_rd_data", 32'(rd), 32'h1234);
    idle(1, 1);

    // abort before pready: write must not land
    xfer(1, 1'b1, 7, 16'h5555, 1, -1, lat, rd, er);
    idle(1, 2);
    xfer(1, 1'b0, 7, 16'h0000, -1, -1, lat, rd, er);
    chk("t4_rd_data", 32'(rd), 32'h0);
    idle(1, 1);

    // out-of-range address on both instances
    for (int d = 0; d < 2; d++) begin
      xfer(d, 1'b1, 50, 16'hAAAA, -1, -1, lat, rd, er);
      chk($sformatf("t5_wr_err[%0d]", d), 32'(er), 32'(exp_oor_err));
      xfer(d, 1'b0, 50, 16'h0000, -1, -1, lat, rd, er);
      chk($sformatf("t5_rd_data[%0d]", d), 32'(rd), 32'h0);
      idle(d, 1);
    end

    // reset during the pready cycle of a write
    xfer(1, 1'b1, 3, 16'h0F0F, -1, 3, lat, rd, er);
    idle(1, 1);
    xfer(1, 1'b0, 3, 16'h0000, -1, -1, lat, rd, er);
    chk("t6_rd_data", 32'(rd), 32'h0);
    xfer(1, 1'b0, 1, 16'h0000, -1, -1, lat, rd, er);
    chk("t6_cleared_data", 32'(rd), 32'h0);
    chk("t6_rd_latency", 32'(lat), 32'd5);
    idle(1, 2);

    @(posedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
